// File: rtl/note_fetch_arbiter_if.sv
// rtl/note_fetch_arbiter_if.sv - lane-request and note-memory signal bundle for note_fetch_arbiter
// The master side is the renderers plus the memory; the slave side is the arbiter itself.
interface note_fetch_arbiter_if #(
  parameter int NUM_LANES = 6,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16
);
  logic                        frame_start;
  logic                        fetch_window;
  logic [NUM_LANES-1:0]        req;
  logic [NUM_LANES*ADDR_W-1:0] req_addr;
  logic [NUM_LANES-1:0]        gnt;
  logic                        mem_en;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_dout;
  logic [NUM_LANES-1:0]        rd_valid;
  logic [DATA_W-1:0]           rd_data;
  logic                        busy;
  logic [7:0]                  grant_count;

  modport master (
    output frame_start, fetch_window, req, req_addr, mem_dout,
    input  gnt, mem_en, mem_addr, rd_valid, rd_data, busy, grant_count
  );

  modport slave (
    input  frame_start, fetch_window, req, req_addr, mem_dout,
    output gnt, mem_en, mem_addr, rd_valid, rd_data, busy, grant_count
  );
endinterface

// File: rtl/note_fetch_arbiter.sv
// rtl/note_fetch_arbiter.sv - round-robin sharing of the note BRAM read port among the lane renderers
// Grants are gated by the fetch window; a tag pipeline routes each returned word back to its lane.
module note_fetch_arbiter #(
  parameter int NUM_LANES = 6,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 2
) (
  input  logic                clk65,
  input  logic                rst_n,
  note_fetch_arbiter_if.slave bus
);
  localparam int LIDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(NUM_LANES - 1);

  logic [NUM_LANES-1:0] gnt_q, gnt_d;
  logic                 mem_en_q;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [LIDX_W-1:0]    last_q, last_d;
  logic [7:0]           grant_count_q, grant_count_d;
  logic [RD_LAT-1:0]    tag_v_q;
  logic [LIDX_W-1:0]    tag_lane_q [RD_LAT];
  logic [DATA_W-1:0]    rd_data_q;

  logic [NUM_LANES-1:0] eligible;
  logic                 win_found;
  logic [LIDX_W-1:0]    win_idx;
  logic                 grant;
  logic [NUM_LANES-1:0] rd_valid;
  logic [DATA_W-1:0]    rd_data;

  // The lane granted last cycle is masked so it cannot win again while dropping req.
  assign eligible = bus.req & ~gnt_q;

  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = (int'(last_q) + k) % NUM_LANES;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = LIDX_W'(idx);
      end
    end
  end

  assign grant = bus.fetch_window && win_found;

  always_comb begin
    gnt_d         = '0;
    mem_addr_d    = mem_addr_q;
    last_d        = last_q;
    grant_count_d = grant_count_q;
    if (grant) begin
      gnt_d[win_idx] = 1'b1;
      mem_addr_d     = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
      last_d         = win_idx;
    end
    // A grant coinciding with frame_start still uses the old pointer and counts as the first grant.
    if (bus.frame_start) begin
      grant_count_d = {7'd0, grant};
      if (!grant) last_d = LAST_LANE;
    end else if (grant && grant_count_q != 8'hFF) begin
      grant_count_d = grant_count_q + 8'd1;
    end
  end

  always_comb begin
    rd_valid = '0;
    if (tag_v_q[RD_LAT-1]) rd_valid[tag_lane_q[RD_LAT-1]] = 1'b1;
  end

  assign rd_data = tag_v_q[RD_LAT-1] ? bus.mem_dout : rd_data_q;

  always_ff @(posedge clk65) begin
    if (!rst_n) begin
      gnt_q         <= '0;
      mem_en_q      <= 1'b0;
      mem_addr_q    <= '0;
      last_q        <= LAST_LANE;
      grant_count_q <= '0;
      tag_v_q       <= '0;
      rd_data_q     <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_lane_q[i] <= '0;
    end else begin
      gnt_q         <= gnt_d;
      mem_en_q      <= grant;
      mem_addr_q    <= mem_addr_d;
      last_q        <= last_d;
      grant_count_q <= grant_count_d;
      rd_data_q     <= rd_data;
      // last_q names the lane of the read currently on mem_en.
      tag_v_q[0]    <= mem_en_q;
      tag_lane_q[0] <= last_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_q[i]    <= tag_v_q[i-1];
        tag_lane_q[i] <= tag_lane_q[i-1];
      end
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_data     = rd_data;
  assign bus.busy        = (|tag_v_q) | mem_en_q;
  assign bus.grant_count = grant_count_q;
endmodule
